// File: rtl/ram_port_arbiter.sv
// Two-port (fetch / load-store) arbiter and byte sequencer for the 1536x8 block RAM.
// Define ARB_RR_EN for round-robin arbitration; otherwise load/store wins every tie.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ack,
    output logic              ls_err,
    output logic [31:0]       ls_rdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [7:0]        ram_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;

    state_t            state_q, state_d;
    logic              port_ls_q, port_ls_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [23:0]       buf_q, buf_d;
    logic              err_q, err_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic              ram_re_q, ram_re_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_raddr_q, ram_raddr_d;
    logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;

    logic              gnt_ls;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size;
    logic              sel_we;
    logic [2:0]        sel_n;
    logic [ADDR_W:0]   sel_last;
    logic              sel_err;
    logic [2:0]        nxt;
    logic [31:0]       rd_word;

`ifdef ARB_RR_EN
    logic              rr_ls_q, rr_ls_d;
    assign gnt_ls = ls_req && (!if_req || rr_ls_q);
`else
    assign gnt_ls = ls_req;
`endif

    assign sel_addr = gnt_ls ? ls_addr : if_addr;
    assign sel_size = gnt_ls ? ls_size : 2'b10;
    assign sel_we   = gnt_ls && ls_we;
    assign sel_n    = (sel_size == 2'b00) ? 3'd1 : (sel_size == 2'b01) ? 3'd2 : 3'd4;
    // Last byte of the access; the extra MSB catches wrap past the top of the address space.
    assign sel_last = {1'b0, sel_addr} + (ADDR_W+1)'(sel_n - 3'd1);
    assign sel_err  = ((sel_size == 2'b01) && sel_addr[0])
                   || ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00))
                   || (sel_size == 2'b11)
                   || (sel_addr[ADDR_W-1 -: 2] == 2'b11)
                   || (sel_last[ADDR_W-1 -: 2] == 2'b11)
                   || sel_last[ADDR_W];

    assign nxt = cnt_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        port_ls_d   = port_ls_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        err_d       = err_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        ram_re_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_raddr_d = ram_raddr_q;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        rd_word     = '0;
`ifdef ARB_RR_EN
        rr_ls_d     = rr_ls_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    port_ls_d = gnt_ls;
                    n_d       = sel_n;
                    base_d    = sel_addr;
                    wdata_d   = ls_wdata;
                    cnt_d     = '0;
                    err_d     = sel_err;
`ifdef ARB_RR_EN
                    rr_ls_d   = !gnt_ls;
`endif
                    if (sel_err) begin
                        state_d = ACK;
                        if (gnt_ls) ls_rdata_d = '0;
                        else        if_rdata_d = '0;
                    end else if (sel_we) begin
                        state_d     = WRITE;
                        ram_we_d    = 1'b1;
                        ram_waddr_d = sel_addr;
                        ram_wdata_d = ls_wdata[7:0];
                    end else begin
                        state_d     = READ;
                        ram_re_d    = 1'b1;
                        ram_raddr_d = sel_addr;
                    end
                end
            end
            READ: begin
                // cnt_q is the byte being addressed; byte cnt_q-1 arrives from the RAM now.
                cnt_d = nxt;
                case (cnt_q)
                    3'd1:    buf_d[7:0]   = ram_rdata;
                    3'd2:    buf_d[15:8]  = ram_rdata;
                    3'd3:    buf_d[23:16] = ram_rdata;
                    default: ;
                endcase
                if (nxt < n_q) begin
                    ram_re_d    = 1'b1;
                    ram_raddr_d = base_q + ADDR_W'(nxt);
                end
                if (cnt_q == n_q) begin
                    case (n_q)
                        3'd1:    rd_word = {24'd0, ram_rdata};
                        3'd2:    rd_word = {16'd0, ram_rdata, buf_q[7:0]};
                        default: rd_word = {ram_rdata, buf_q};
                    endcase
                    if (port_ls_q) ls_rdata_d = rd_word;
                    else           if_rdata_d = rd_word;
                    state_d = ACK;
                end
            end
            WRITE: begin
                cnt_d = nxt;
                if (nxt < n_q) begin
                    ram_we_d    = 1'b1;
                    ram_waddr_d = base_q + ADDR_W'(nxt);
                    ram_wdata_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
                end else begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            port_ls_q   <= 1'b0;
            n_q         <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_raddr_q <= '0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
`ifdef ARB_RR_EN
            rr_ls_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            port_ls_q   <= port_ls_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            ram_re_q    <= ram_re_d;
            ram_we_q    <= ram_we_d;
            ram_raddr_q <= ram_raddr_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
`ifdef ARB_RR_EN
            rr_ls_q     <= rr_ls_d;
`endif
        end
    end

    assign if_ack    = (state_q == ACK) && !port_ls_q;
    assign ls_ack    = (state_q == ACK) &&  port_ls_q;
    assign if_err    = if_ack && err_q;
    assign ls_err    = ls_ack && err_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign ram_re    = ram_re_q;
    assign ram_we    = ram_we_q;
    assign ram_raddr = ram_raddr_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural byte RAM.
// Expected acks are queued by the stimulus and popped by an ack monitor.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    localparam int unsigned AW = 11;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack, if_err;
    logic [31:0]   if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [1:0]    ls_size = '0;
    logic [AW-1:0] ls_addr = '0;
    logic [31:0]   ls_wdata = '0;
    logic          ls_ack, ls_err;
    logic [31:0]   ls_rdata;
    logic          ram_re, ram_we;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [7:0]    ram_rdata;
    logic [7:0]    ram_wdata;

    ram_port_arbiter #(.ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Byte RAM: one-cycle read latency, preloaded on the first clock edge.
    logic [7:0] mem [0:2047];
    bit         loaded;
    always @(posedge CLK) begin
        if (!loaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
            mem[11'h100] <= 8'h11;
            mem[11'h101] <= 8'h22;
            mem[11'h102] <= 8'h33;
            mem[11'h103] <= 8'h44;
            mem[11'h5FF] <= 8'h5A;
            loaded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        bit          chk_rd;
        int unsigned cyc;
    } exp_t;

    exp_t          q_if[$];
    exp_t          q_ls[$];
    logic [AW-1:0] re_log[$];
    logic [AW+7:0] we_log[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void score(input string nm, input exp_t e, input logic err, input logic [31:0] rd);
        chk({nm, "_err"}, 32'(err), 32'(e.err));
        if (e.chk_rd) chk({nm, "_rdata"}, rd, e.rdata);
        chk({nm, "_ack_cycle"}, cyc, e.cyc);
    endfunction

    always @(negedge CLK) begin
        if (ram_re) re_log.push_back(ram_raddr);
        if (ram_we) we_log.push_back({ram_waddr, ram_wdata});
        if (if_ack) begin
            if (q_if.size() == 0) begin
                checks++; failures++;
                $display("FAIL if_ack_unexpected actual=1 required=0 (cycle %0d)", cyc);
            end else score("if", q_if.pop_front(), if_err, if_rdata);
        end
        if (ls_ack) begin
            if (q_ls.size() == 0) begin
                checks++; failures++;
                $display("FAIL ls_ack_unexpected actual=1 required=0 (cycle %0d)", cyc);
            end else score("ls", q_ls.pop_front(), ls_err, ls_rdata);
        end
    end

    // Waits for the port's ack; after the grant cycle the request fields are scrambled,
    // which the arbiter must ignore because it latched them at grant.
    task automatic wait_ack(input bit is_ls);
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (is_ls ? ls_ack : if_ack) begin
                seen = 1'b1;
                break;
            end
            if (k == 0) begin
                if_addr  = ~if_addr;
                ls_addr  = ~ls_addr;
                ls_wdata = ~ls_wdata;
                ls_size  = ~ls_size;
                ls_we    = ~ls_we;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL ack_timeout actual=no_ack required=ack (cycle %0d)", cyc);
        end
    endtask

    task automatic if_op(input logic [AW-1:0] a, input logic e, input logic [31:0] rd,
                         input int unsigned lat);
        exp_t x;
        @(negedge CLK);
        if_req = 1'b1; if_addr = a;
        x.err = e; x.rdata = rd; x.chk_rd = 1'b1; x.cyc = cyc + lat;
        q_if.push_back(x);
        wait_ack(1'b0);
        if_req = 1'b0;
    endtask

    task automatic ls_op(input logic we, input logic [1:0] sz, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic e, input logic [31:0] rd,
                         input bit chk_rd, input int unsigned lat);
        exp_t x;
        @(negedge CLK);
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
        x.err = e; x.rdata = rd; x.chk_rd = chk_rd; x.cyc = cyc + lat;
        q_ls.push_back(x);
        wait_ack(1'b1);
        ls_req = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_if_ack"},    32'(if_ack),    32'd0);
        chk({tag, "_if_err"},    32'(if_err),    32'd0);
        chk({tag, "_if_rdata"},  if_rdata,       32'd0);
        chk({tag, "_ls_ack"},    32'(ls_ack),    32'd0);
        chk({tag, "_ls_err"},    32'(ls_err),    32'd0);
        chk({tag, "_ls_rdata"},  ls_rdata,       32'd0);
        chk({tag, "_ram_re"},    32'(ram_re),    32'd0);
        chk({tag, "_ram_we"},    32'(ram_we),    32'd0);
        chk({tag, "_ram_raddr"}, 32'(ram_raddr), 32'd0);
        chk({tag, "_ram_waddr"}, 32'(ram_waddr), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned nack;

        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RST = 1'b0;

        // Error grants: immediate ack, zero data, no RAM traffic.
        re_log.delete(); we_log.delete();
        ls_op(1'b0, 2'b10, 11'h005, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        if_op(11'h600, 1'b1, 32'h0, 1);
        if_op(11'h102, 1'b1, 32'h0, 1);
        ls_op(1'b0, 2'b11, 11'h100, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        ls_op(1'b0, 2'b01, 11'h203, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        ls_op(1'b0, 2'b00, 11'h600, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        ls_op(1'b1, 2'b10, 11'h0FE, 32'h12345678, 1'b1, 32'h0, 1'b1, 1);
        chk("err_no_ram_re", re_log.size(), 32'd0);
        chk("err_no_ram_we", we_log.size(), 32'd0);

        // Word fetch and its RAM read address sequence.
        re_log.delete();
        if_op(11'h100, 1'b0, 32'h44332211, 6);
        chk("fetch_re_count", re_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < re_log.size(); i++)
            chk("fetch_raddr", 32'(re_log[i]), 32'h100 + 32'(i));

        // Half store, then loads of various sizes including the last valid byte.
        we_log.delete();
        ls_op(1'b1, 2'b01, 11'h202, 32'h0000BEEF, 1'b0, 32'h0, 1'b0, 3);
        chk("store_we_count", we_log.size(), 32'd2);
        if (we_log.size() >= 2) begin
            chk("store_beat0", 32'(we_log[0]), 32'h202EF);
            chk("store_beat1", 32'(we_log[1]), 32'h203BE);
        end
        ls_op(1'b0, 2'b00, 11'h203, 32'h0, 1'b0, 32'h000000BE, 1'b1, 3);
        ls_op(1'b0, 2'b01, 11'h202, 32'h0, 1'b0, 32'h0000BEEF, 1'b1, 4);
        ls_op(1'b0, 2'b00, 11'h5FF, 32'h0, 1'b0, 32'h0000005A, 1'b1, 3);
        ls_op(1'b0, 2'b10, 11'h100, 32'h0, 1'b0, 32'h44332211, 1'b1, 6);

        // Word store aborted by reset in cycle 3: only the first two bytes land.
        @(negedge CLK);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 11'h010; ls_wdata = 32'hA5A5A5A5;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        check_idle_outputs("midrst");
        ls_req = 1'b0;
        repeat (2) @(negedge CLK);
        chk("midrst_mem010", 32'(mem[11'h010]), 32'hA5);
        chk("midrst_mem011", 32'(mem[11'h011]), 32'hA5);
        chk("midrst_mem012", 32'(mem[11'h012]), 32'h00);
        chk("midrst_mem013", 32'(mem[11'h013]), 32'h00);
        RST = 1'b0;

        // Both ports request continuously through three acks.
        @(negedge CLK);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 11'h100;
        if_req = 1'b1; if_addr = 11'h100;
        c0 = cyc;
`ifdef ARB_RR_EN
        q_ls.push_back('{err: 1'b0, rdata: 32'h11,       chk_rd: 1'b1, cyc: c0 + 3});
        q_if.push_back('{err: 1'b0, rdata: 32'h44332211, chk_rd: 1'b1, cyc: c0 + 10});
        q_ls.push_back('{err: 1'b0, rdata: 32'h11,       chk_rd: 1'b1, cyc: c0 + 14});
`else
        q_ls.push_back('{err: 1'b0, rdata: 32'h11, chk_rd: 1'b1, cyc: c0 + 3});
        q_ls.push_back('{err: 1'b0, rdata: 32'h11, chk_rd: 1'b1, cyc: c0 + 7});
        q_ls.push_back('{err: 1'b0, rdata: 32'h11, chk_rd: 1'b1, cyc: c0 + 11});
`endif
        nack = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (ls_ack || if_ack) nack++;
            if (nack == 3) break;
        end
        ls_req = 1'b0; if_req = 1'b0;
        chk("arb_ack_count", nack, 32'd3);

        repeat (5) @(negedge CLK);
        chk("q_if_drained", q_if.size(), 32'd0);
        chk("q_ls_drained", q_ls.size(), 32'd0);
        chk("final_ram_re", 32'(ram_re), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
